// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the two-master arbiter on the dual-port RAM's port A.
package dpram_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int BEAT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

endpackage

// File: rtl/dpram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing RAM port A between two valid/ready masters,
// with a 1-cycle read-response channel per master.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(MAX_BURST);
  localparam logic [BEAT_W-1:0] BEAT_SAT  = '1;

  owner_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              last_served_q, last_served_d;
  logic              pend0_q, pend0_d;
  logic              pend1_q, pend1_d;

  logic gnt_valid;
  logic gnt_port;

  // Grant selection. Held off while reset is asserted so the RAM pins and
  // ready outputs are quiet even if masters already present requests.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        OWN0: begin
          if (req0_valid && beat_cnt_q < BURST_LIM) begin
            gnt_valid = 1'b1; gnt_port = 1'b0;
          end else if (req1_valid) begin
            gnt_valid = 1'b1; gnt_port = 1'b1;
          end else if (req0_valid) begin
            gnt_valid = 1'b1; gnt_port = 1'b0;
          end
        end
        OWN1: begin
          if (req1_valid && beat_cnt_q < BURST_LIM) begin
            gnt_valid = 1'b1; gnt_port = 1'b1;
          end else if (req0_valid) begin
            gnt_valid = 1'b1; gnt_port = 1'b0;
          end else if (req1_valid) begin
            gnt_valid = 1'b1; gnt_port = 1'b1;
          end
        end
        default: begin
          if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1; gnt_port = ~last_served_q;
          end else if (req0_valid) begin
            gnt_valid = 1'b1; gnt_port = 1'b0;
          end else if (req1_valid) begin
            gnt_valid = 1'b1; gnt_port = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    req0_ready  = gnt_valid & ~gnt_port;
    req1_ready  = gnt_valid &  gnt_port;
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (gnt_valid) begin
      ram_address = gnt_port ? req1_addr  : req0_addr;
      ram_data    = gnt_port ? req1_wdata : req0_wdata;
      ram_wren    = gnt_port ? req1_we    : req0_we;
    end
  end

  always_comb begin
    state_d       = IDLE;
    beat_cnt_d    = '0;
    last_served_d = last_served_q;
    if (gnt_valid) begin
      state_d       = gnt_port ? OWN1 : OWN0;
      last_served_d = gnt_port;
      // Continuing owner extends its burst; a new owner starts at one beat.
      if (state_d == state_q)
        beat_cnt_d = (beat_cnt_q == BEAT_SAT) ? BEAT_SAT : beat_cnt_q + 1'b1;
      else
        beat_cnt_d = BEAT_W'(1);
    end
    pend0_d = req0_valid & req0_ready & ~req0_we;
    pend1_d = req1_valid & req1_ready & ~req1_we;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      last_served_q <= 1'b1;
      pend0_q       <= 1'b0;
      pend1_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      last_served_q <= last_served_d;
      pend0_q       <= pend0_d;
      pend1_q       <= pend1_d;
    end
  end

  // The RAM's registered output lines up with the pending flag one cycle after acceptance.
  always_comb begin
    rsp0_valid = pend0_q;
    rsp1_valid = pend1_q;
    rsp0_rdata = pend0_q ? ram_q : '0;
    rsp1_rdata = pend1_q ? ram_q : '0;
  end

endmodule
